// File: rtl/apb4_mem_pkg.sv
// Shared types and sizing helpers for the APB4 register-file memory slave.
package apb4_mem_pkg;

    typedef enum logic {IDLE, ACCESS} state_t;

    localparam int WAIT_W = 4;

    function automatic int strb_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int off_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// Loadable down-counter that paces the access phase; zero marks the ready cycle.
module apb4_wait_ctr
    import apb4_mem_pkg::*;
(
    input  logic              pclk,
    input  logic              presetn,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    output logic [WAIT_W-1:0] value,
    output logic              zero
);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            value <= '0;
        end else if (load) begin
            value <= load_val;
        end else if (en && (value != '0)) begin
            value <= value - 1'b1;
        end
    end

    assign zero = (value == '0);

endmodule

// File: rtl/apb4_mem_slave.sv
// APB4 completer backed by a byte-strobed register file with wait states and PSLVERR.
// Optional APB_PROT_CHECK_EN: upper half of memory rejects unprivileged accesses.
module apb4_mem_slave
    import apb4_mem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 0
) (
    input  logic                       pclk,
    input  logic                       presetn,
    input  logic [ADDR_WIDTH-1:0]      paddr,
    input  logic                       psel,
    input  logic                       penable,
    input  logic                       pwrite,
    input  logic [DATA_WIDTH-1:0]      pwdata,
    input  logic [DATA_WIDTH/8-1:0]    pstrb,
    input  logic [2:0]                 pprot,
    output logic [DATA_WIDTH-1:0]      prdata,
    output logic                       pready,
    output logic                       pslverr
);

    localparam int STRB_W = strb_width(DATA_WIDTH);
    localparam int OFF_W  = off_width(DATA_WIDTH);
    localparam int IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK  = ADDR_WIDTH'(STRB_W - 1);
    localparam logic [WAIT_W-1:0]     WAIT_LOAD = WAIT_W'(WAIT_STATES);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   paddr_q;
    logic                    pwrite_q;
    logic [2:0]              pprot_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic [WAIT_W-1:0]       cnt;
    logic                    cnt_zero;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic [IDX_W-1:0]        idx;
    logic                    range_err, align_err, prot_err, acc_err;
    logic                    setup, done, do_write;
    logic                    unused_bits;

    function automatic logic [DATA_WIDTH-1:0] merge_lanes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_word;
        for (int i = 0; i < STRB_W; i++) begin
            if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
        end
        return res;
    endfunction

    assign setup = (state == IDLE) && psel && !penable;

    apb4_wait_ctr u_wait_ctr (
        .pclk     (pclk),
        .presetn  (presetn),
        .load     (setup),
        .load_val (WAIT_LOAD),
        .en       (state == ACCESS),
        .value    (cnt),
        .zero     (cnt_zero)
    );

    // Decode is done on the setup-captured address so it is stable for the whole access.
    assign word_addr = paddr_q >> OFF_W;
    assign idx       = word_addr[IDX_W-1:0];
    assign range_err = |(word_addr >> IDX_W);
    assign align_err = |(paddr_q & OFF_MASK);

`ifdef APB_PROT_CHECK_EN
    assign prot_err    = idx[IDX_W-1] && !pprot_q[0];
    assign unused_bits = ^{cnt, pprot_q[2:1]};
`else
    assign prot_err    = 1'b0;
    assign unused_bits = ^{cnt, pprot_q};
`endif

    assign acc_err  = range_err || align_err || prot_err;
    assign pready   = (state == ACCESS) && cnt_zero;
    assign done     = pready && psel && penable;
    assign do_write = done && pwrite_q && !acc_err;
    assign pslverr  = pready && acc_err;
    assign prdata   = (pready && !pwrite_q && !acc_err) ? mem[idx] : '0;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state    <= IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            pprot_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (psel && !penable) begin
                        paddr_q  <= paddr;
                        pwrite_q <= pwrite;
                        pprot_q  <= pprot;
                        state    <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Dropping psel mid-access abandons the transfer without side effects.
                    if (!psel || done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_write) begin
            mem[idx] <= merge_lanes(mem[idx], pwdata, pstrb);
        end
    end

endmodule
